// File: rtl/bmp_pkg.sv
`default_nettype none
// ============================================================================
// bmp_pkg : register map, STATUS/CTRL bit positions and FSM states for the
//           BMP command queue.                               Revision 1.0
// ============================================================================
package bmp_pkg;

  localparam logic [1:0] OFS_X    = 2'd0;
  localparam logic [1:0] OFS_Y    = 2'd1;
  localparam logic [1:0] OFS_CTRL = 2'd2;
  localparam logic [1:0] OFS_STAT = 2'd3;

  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_MSB = 3;
  localparam int STAT_FULL    = 4;
  localparam int STAT_EMPTY   = 5;
  localparam int STAT_OVF     = 6;
  localparam int STAT_TMO     = 7;
  localparam int STAT_BUSY    = 8;
  localparam int STAT_FLUSH   = 15;

  localparam int CTL_ADD_IMG = 0;
  localparam int CTL_IDX_LSB = 1;
  localparam int CTL_IDX_MSB = 5;
  localparam int CTL_REM     = 15;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] ctrl;
  } bmp_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_X = 3'd1,
    S_WR_Y = 3'd2,
    S_WR_C = 3'd3,
    S_WAIT = 3'd4
  } bmp_state_t;

endpackage
`default_nettype wire

// File: rtl/bmp_cmd_fifo.sv
`default_nettype none
// ============================================================================
// bmp_cmd_fifo : synchronous command FIFO with push/pop/flush and registered
//                full/empty flags.                            Revision 1.0
// ============================================================================
module bmp_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A pop frees a slot in the same cycle, so a push onto a full FIFO still lands.
  assign pop_ok  = pop_i & ~empty_q & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full_q | pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bmp_cmd_queue.sv
`default_nettype none
// ============================================================================
// bmp_cmd_queue : queues CPU draw commands and replays each one to the BMP
//                 display as a paced X/Y/CTRL write burst.   Revision 1.0
// ============================================================================
module bmp_cmd_queue
  import bmp_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] BASE     = 16'hC008,
  parameter int          WAIT_MIN = 2,
  parameter logic [19:0] WAIT_MAX = 20'd800000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_sel,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        bmp_sel,
  output logic [15:0] bmp_addr,
  output logic [15:0] bmp_data,
  input  logic        plc_busy,
  output logic        q_full,
  output logic        q_empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  bmp_state_t        state_q, state_d;
  logic [19:0]       wait_cnt_q, wait_cnt_d;
  logic [9:0]        x_sh_q;
  logic [8:0]        y_sh_q;
  logic [8:0]        y_q, y_d;
  logic [15:0]       ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d, tmo_q, tmo_d;
  logic              sel_q, sel_d;
  logic [15:0]       addr_q, addr_d, data_q, data_d;

  logic [15:0]       ofs;
  logic              hit, wr_x, wr_y, wr_ctrl, wr_stat, rd_stat;
  logic              flush, pop, drop, tmo_set, eng_busy;
  logic [CW-1:0]     count;
  logic [3:0]        cnt4;
  logic [$bits(bmp_cmd_t)-1:0] head_raw;
  bmp_cmd_t          head;
  logic [15:0]       stat;

  assign ofs     = cpu_addr - BASE;
  assign hit     = cpu_sel & (ofs[15:2] == 14'd0);
  assign wr_x    = hit & cpu_we & (ofs[1:0] == OFS_X);
  assign wr_y    = hit & cpu_we & (ofs[1:0] == OFS_Y);
  assign wr_ctrl = hit & cpu_we & (ofs[1:0] == OFS_CTRL);
  assign wr_stat = hit & cpu_we & (ofs[1:0] == OFS_STAT);
  assign rd_stat = hit & ~cpu_we & (ofs[1:0] == OFS_STAT);
  assign flush   = wr_stat & cpu_wdata[STAT_FLUSH];
  assign drop    = wr_ctrl & q_full & ~pop;

  bmp_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(bmp_cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_ctrl),
    .wdata_i ({x_sh_q, y_sh_q, cpu_wdata}),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head_raw),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (count)
  );

  assign head = bmp_cmd_t'(head_raw);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      // A flush in the same cycle wins, so no burst is started from the dropped head.
      S_IDLE: begin
        if (~q_empty & ~plc_busy & ~flush) begin
          pop     = 1'b1;
          state_d = S_WR_X;
        end
      end
      S_WR_X: state_d = S_WR_Y;
      S_WR_Y: state_d = S_WR_C;
      S_WR_C: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 20'd1;
        if (plc_busy && (wait_cnt_q == WAIT_MAX - 20'd1)) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else if (!plc_busy && (wait_cnt_q >= 20'(WAIT_MIN - 1))) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe/address/data are registered from the next state; X comes straight
  // from the FIFO head because the out-register loads on the same edge.
  always_comb begin
    y_d    = y_q;
    ctrl_d = ctrl_q;
    sel_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      y_d    = head.y;
      ctrl_d = head.ctrl;
    end
    case (state_d)
      S_WR_X: begin
        sel_d  = 1'b1;
        addr_d = BASE;
        data_d = {6'b0, head.x};
      end
      S_WR_Y: begin
        sel_d  = 1'b1;
        addr_d = BASE + 16'd1;
        data_d = {7'b0, y_q};
      end
      S_WR_C: begin
        sel_d  = 1'b1;
        addr_d = BASE + 16'd2;
        data_d = ctrl_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    tmo_d = tmo_q;
    if (wr_stat & cpu_wdata[STAT_OVF]) ovf_d = 1'b0;
    if (drop)                          ovf_d = 1'b1;
    if (wr_stat & cpu_wdata[STAT_TMO]) tmo_d = 1'b0;
    if (tmo_set)                       tmo_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      x_sh_q     <= '0;
      y_sh_q     <= '0;
      y_q        <= '0;
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (wr_x) x_sh_q <= cpu_wdata[9:0];
      if (wr_y) y_sh_q <= cpu_wdata[8:0];
      y_q        <= y_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign eng_busy = (state_q != S_IDLE);
  assign cnt4     = (32'(count) > 32'd15) ? 4'hF : 4'(count);

  always_comb begin
    stat                             = '0;
    stat[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt4;
    stat[STAT_FULL]                  = q_full;
    stat[STAT_EMPTY]                 = q_empty;
    stat[STAT_OVF]                   = ovf_q;
    stat[STAT_TMO]                   = tmo_q;
    stat[STAT_BUSY]                  = eng_busy;
  end

  assign cpu_rdata = rd_stat ? stat : 16'h0000;
  assign bmp_sel   = sel_q;
  assign bmp_addr  = addr_q;
  assign bmp_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_bmp_cmd_queue.sv
`default_nettype none
// ============================================================================
// tb_bmp_cmd_queue : scoreboard bench for the BMP command queue (WAIT_MAX=100).
//                                                             Revision 1.0
// ============================================================================
module tb_bmp_cmd_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_sel = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [15:0] cpu_wdata = 16'h0;
  logic [15:0] cpu_rdata;
  logic        bmp_sel;
  logic [15:0] bmp_addr;
  logic [15:0] bmp_data;
  logic        plc_busy;
  logic        q_full;
  logic        q_empty;

  logic        plc_force = 1'b0;
  logic        plc_model = 1'b0;
  logic        placer_en = 1'b0;
  assign plc_busy = plc_force | plc_model;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q [$];

  bmp_cmd_queue #(
    .DEPTH    (8),
    .BASE     (16'hC008),
    .WAIT_MIN (2),
    .WAIT_MAX (20'd100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_sel   (cpu_sel),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .bmp_sel   (bmp_sel),
    .bmp_addr  (bmp_addr),
    .bmp_data  (bmp_data),
    .plc_busy  (plc_busy),
    .q_full    (q_full),
    .q_empty   (q_empty)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
  endtask

  task automatic read_status(output logic [15:0] v);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC00B;
    #1;
    v = cpu_rdata;
    cpu_sel = 1'b0; cpu_addr = 16'h0;
  endtask

  task automatic status_is(input string name, input logic [15:0] exp);
    logic [15:0] v;
    read_status(v);
    check(name, {16'h0, v}, {16'h0, exp});
  endtask

  // Only the first nexp beats of the burst are expected to reach the display.
  task automatic push_cmd(input logic [9:0] x, input logic [8:0] y, input logic [15:0] c,
                          input int nexp);
    logic [31:0] beats [3];
    beats[0] = {16'hC008, 6'b0, x};
    beats[1] = {16'hC009, 7'b0, y};
    beats[2] = {16'hC00A, c};
    cpu_write(16'hC008, {6'b0, x});
    cpu_write(16'hC009, {7'b0, y});
    for (int i = 0; i < nexp; i++) exp_q.push_back(beats[i]);
    cpu_write(16'hC00A, c);
  endtask

  task automatic wait_strobe(input logic [15:0] a, input int maxc);
    int n = 0;
    while (!(bmp_sel && bmp_addr == a) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(bmp_sel && bmp_addr == a)) begin
      checks++;
      errors++;
      $display("FAIL wait_strobe_%h: no strobe after %0d cycles, expected one", a, maxc);
    end
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every display strobe must match the head of the expected queue.
  initial begin
    int          last_cyc = -10;
    logic        prev_busy = 1'b0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bmp_sel) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got %h/%h expected none", bmp_addr, bmp_data);
        end else begin
          e = exp_q.pop_front();
          check("bmp_write", {bmp_addr, bmp_data}, e);
          if (bmp_addr != 16'hC008) check("strobe_gap", 32'(cyc - last_cyc), 32'd1);
          else                      check("x_after_placer_idle", {31'b0, prev_busy}, 32'd0);
        end
        last_cyc = cyc;
      end
      prev_busy = plc_busy;
    end
  end

  // Placer model: busy for 40 cycles starting one cycle after each CTRL write.
  initial begin
    forever begin
      @(negedge clk);
      if (placer_en && bmp_sel && bmp_addr == 16'hC00A) begin
        @(posedge clk); #1;
        plc_model = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        plc_model = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_bmp_sel",  {31'b0, bmp_sel}, 32'd0);
    check("rst_bmp_addr", {16'h0, bmp_addr}, 32'd0);
    check("rst_bmp_data", {16'h0, bmp_data}, 32'd0);
    check("rst_q_full",   {31'b0, q_full}, 32'd0);
    check("rst_q_empty",  {31'b0, q_empty}, 32'd1);
    status_is("rst_status", 16'h0020);
    rst_n = 1'b1;

    // Single command, placer idle: strobe two cycles after the CTRL push.
    push_cmd(10'd100, 9'd50, 16'h0007, 3);
    check("lat_pop_cycle_no_sel", {31'b0, bmp_sel}, 32'd0);
    @(posedge clk); #1;
    check("lat_first_sel", {31'b0, bmp_sel}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    status_is("single_status", 16'h0020);

    // Three commands paced by a busy placer.
    placer_en = 1'b1;
    push_cmd(10'd1, 9'd2, 16'h0003, 3);
    push_cmd(10'd4, 9'd5, 16'h0006, 3);
    push_cmd(10'd7, 9'd8, 16'h0009, 3);
    status_is("paced_status_busy", 16'h0102);
    wait_drain(400);
    repeat (60) @(posedge clk);
    #1;
    status_is("paced_status_done", 16'h0020);
    placer_en = 1'b0;

    // Overflow: nine pushes with the placer stuck busy.
    plc_force = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("full_before_8th", {31'b0, q_full}, 32'd0);
      push_cmd(10'(i + 16), 9'(i + 32), 16'(16'h0100 + i), 3);
    end
    check("full_after_8th", {31'b0, q_full}, 32'd1);
    push_cmd(10'd999, 9'd499, 16'hDEAD, 0);
    status_is("ovf_status", 16'h0058);
    cpu_write(16'hC00B, 16'h0040);
    status_is("ovf_cleared", 16'h0018);
    plc_force = 1'b0;
    wait_drain(200);
    repeat (10) @(posedge clk);
    #1;
    status_is("ovf_drained", 16'h0020);

    // Timeout: placer stuck busy after the burst.
    push_cmd(10'd1, 9'd2, 16'h0003, 3);
    wait_strobe(16'hC00A, 20);
    plc_force = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    status_is("tmo_wait_cycle100", 16'h0120);
    @(posedge clk); #1;
    status_is("tmo_set", 16'h00A0);
    plc_force = 1'b0;
    cpu_write(16'hC00B, 16'h0080);
    status_is("tmo_cleared", 16'h0020);

    // Flush during an in-flight burst.
    plc_force = 1'b1;
    push_cmd(10'd300, 9'd200, 16'h8021, 3);
    push_cmd(10'd301, 9'd201, 16'h0022, 0);
    push_cmd(10'd302, 9'd202, 16'h0023, 0);
    push_cmd(10'd303, 9'd203, 16'h0024, 0);
    status_is("flush_prefill", 16'h0004);
    plc_force = 1'b0;
    @(posedge clk); #1;
    check("flush_in_wr_x", {31'b0, bmp_sel}, 32'd1);
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC00B; cpu_wdata = 16'h8000;
    @(posedge clk); #1;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    status_is("flush_midburst", 16'h0120);
    repeat (20) @(posedge clk);
    #1;
    status_is("flush_done", 16'h0020);
    check("flush_drained", 32'(exp_q.size()), 32'd0);

    // Reset during WR_Y abandons the command.
    push_cmd(10'd5, 9'd6, 16'h0021, 1);
    wait_strobe(16'hC009, 20);
    rst_n = 1'b0;
    #1;
    check("rstmid_bmp_sel",  {31'b0, bmp_sel}, 32'd0);
    check("rstmid_q_empty",  {31'b0, q_empty}, 32'd1);
    check("rstmid_bmp_addr", {16'h0, bmp_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_idle_empty", {31'b0, q_empty}, 32'd1);
    exp_q.push_back({16'hC008, 16'h0000});
    exp_q.push_back({16'hC009, 16'h0000});
    exp_q.push_back({16'hC00A, 16'h1234});
    cpu_write(16'hC00A, 16'h1234);
    wait_drain(50);
    repeat (10) @(posedge clk);
    #1;
    status_is("final_status", 16'h0020);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
